cond_unit: RTL and testbench

//   Conditional-execution stage for the multicycle ARM core; sits between the main control FSM and the datapath.

---
 rtl/cond_unit.sv | 83 ++++++++
 tb/tb_cond_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Conditional-execution stage for the multicycle ARM core: holds NZCV, evaluates Cond once
// per instruction in DECODE, and gates the FSM's raw write strobes with the frozen result.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       ALUOp,
  input  logic       IRWrite,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic [3:0] Flags,
  output logic       CondExReg,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       decode_q, decode_d;
  logic       cond_ex;
  logic       wr_nz, wr_cv;

  // Reserved encoding 1111 evaluates false so the instruction is fully suppressed.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = !c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = c & !z;
      4'b1001: cond_eval = !c | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    cond_ex   = cond_eval(Cond, flags_q);
    decode_d  = IRWrite;
    cond_ex_d = decode_q ? cond_ex : cond_ex_q;
    // Flag writes use the pre-edge CondExReg, so a same-edge reload never gates them.
    wr_nz     = FlagW[1] & ALUOp & cond_ex_q;
    wr_cv     = FlagW[0] & ALUOp & cond_ex_q;
    flags_d   = flags_q;
    if (wr_nz) flags_d[3:2] = ALUFlags[3:2];
    if (wr_cv) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
      decode_q  <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      decode_q  <= decode_d;
    end
  end

  assign Flags     = flags_q;
  assign CondExReg = cond_ex_q;
  // Fetch advances the PC regardless of condition; all strobes are held low during reset.
  assign PCWrite   = !reset & (NextPC | (PCS & cond_ex_q));
  assign RegWrite  = !reset & RegW & cond_ex_q;
  assign MemWrite  = !reset & MemW & cond_ex_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: walks reset, decode/execute sequences and condition-code corners.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       ALUOp, IRWrite, PCS, NextPC, RegW, MemW;
  logic [3:0] Flags;
  logic       CondExReg, PCWrite, RegWrite, MemWrite;

  int vectors = 0;
  int miscompares = 0;

  cond_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .ALUOp(ALUOp), .IRWrite(IRWrite), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Flags(Flags), .CondExReg(CondExReg), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ALUFlags = 4'b0000; FlagW = 2'b00; ALUOp = 1'b0; IRWrite = 1'b0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // FETCH cycle (IRWrite) then DECODE cycle; CondExReg is loaded at the end of DECODE.
  task automatic do_decode(input logic [3:0] c);
    Cond = c; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    tick();
  endtask

  task automatic set_flags(input logic [3:0] f);
    do_decode(4'b1110);
    ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = f;
    tick();
    ALUOp = 1'b0; FlagW = 2'b00;
  endtask

  initial begin
    Cond = 4'b0000;
    clear_inputs();
    reset = 1'b1;
    NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    #12;
    chk("rst_pcwrite", {3'b0, PCWrite}, 4'h0);
    chk("rst_regwrite", {3'b0, RegWrite}, 4'h0);
    chk("rst_memwrite", {3'b0, MemWrite}, 4'h0);
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_condex", {3'b0, CondExReg}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    tick();

    // AL instruction writes all four flags and enables its register write
    do_decode(4'b1110);
    chk("al_condex", {3'b0, CondExReg}, 4'h1);
    ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0110;
    #1;
    chk("al_flags_pre_edge", Flags, 4'b0000);
    tick();
    chk("al_flags", Flags, 4'b0110);
    ALUOp = 1'b0; FlagW = 2'b00; RegW = 1'b1;
    #1;
    chk("al_regwrite", {3'b0, RegWrite}, 4'h1);
    RegW = 1'b0;

    // BEQ taken and not taken
    set_flags(4'b0100);
    do_decode(4'b0000);
    chk("beq_z1_condex", {3'b0, CondExReg}, 4'h1);
    PCS = 1'b1; #1;
    chk("beq_z1_pcwrite", {3'b0, PCWrite}, 4'h1);
    PCS = 1'b0;
    set_flags(4'b0000);
    do_decode(4'b0000);
    PCS = 1'b1; #1;
    chk("beq_z0_pcwrite", {3'b0, PCWrite}, 4'h0);
    NextPC = 1'b1; #1;
    chk("nextpc_ungated", {3'b0, PCWrite}, 4'h1);
    PCS = 1'b0; NextPC = 1'b0;

    // NE fails with Z=1: no flag update, no register write
    set_flags(4'b0100);
    do_decode(4'b0001);
    chk("ne_condex", {3'b0, CondExReg}, 4'h0);
    ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1001;
    tick();
    chk("ne_flags_held", Flags, 4'b0100);
    ALUOp = 1'b0; FlagW = 2'b00; RegW = 1'b1; #1;
    chk("ne_regwrite", {3'b0, RegWrite}, 4'h0);
    RegW = 1'b0;

    // EQ with S: execute clears Z but CondExReg stays frozen through writeback
    do_decode(4'b0000);
    ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    chk("eqs_flags", Flags, 4'b0000);
    ALUOp = 1'b0; FlagW = 2'b00;
    tick();
    RegW = 1'b1; #1;
    chk("eqs_condex_frozen", {3'b0, CondExReg}, 4'h1);
    chk("eqs_regwrite", {3'b0, RegWrite}, 4'h1);
    RegW = 1'b0;

    // Independent NZ / CV halves and ALUOp gating
    ALUOp = 1'b1; FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    chk("nz_half_only", Flags, 4'b1100);
    FlagW = 2'b01; ALUFlags = 4'b0001;
    tick();
    chk("cv_half_only", Flags, 4'b1101);
    ALUOp = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    chk("aluop_gate", Flags, 4'b1101);
    FlagW = 2'b00;

    // Signed compares with N=1 V=0, reserved encoding, and memory write gating
    set_flags(4'b1000);
    do_decode(4'b1010);
    chk("ge_condex", {3'b0, CondExReg}, 4'h0);
    do_decode(4'b1011);
    chk("lt_condex", {3'b0, CondExReg}, 4'h1);
    MemW = 1'b1; #1;
    chk("lt_memwrite", {3'b0, MemWrite}, 4'h1);
    MemW = 1'b0;
    do_decode(4'b1100);
    chk("gt_condex", {3'b0, CondExReg}, 4'h0);
    do_decode(4'b1101);
    chk("le_condex", {3'b0, CondExReg}, 4'h1);
    do_decode(4'b1111);
    chk("nv_condex", {3'b0, CondExReg}, 4'h0);
    MemW = 1'b1; #1;
    chk("nv_memwrite", {3'b0, MemWrite}, 4'h0);
    MemW = 1'b0;

    // Forced overlap of DECODE and flag write: old CondExReg gates, pre-edge flags evaluated
    Cond = 4'b0100; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0; ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    chk("ovl1_flags", Flags, 4'b1000);
    chk("ovl1_condex", {3'b0, CondExReg}, 4'h1);
    ALUOp = 1'b0; FlagW = 2'b00;
    Cond = 4'b0101; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0; ALUOp = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    chk("ovl2_flags", Flags, 4'b0000);
    chk("ovl2_condex", {3'b0, CondExReg}, 4'h0);
    ALUOp = 1'b0; FlagW = 2'b00;

    // HI / LS with C=1 Z=0
    set_flags(4'b0010);
    do_decode(4'b1000);
    chk("hi_condex", {3'b0, CondExReg}, 4'h1);
    do_decode(4'b1001);
    chk("ls_condex", {3'b0, CondExReg}, 4'h0);

    // Asynchronous reset mid-instruction
    set_flags(4'b1111);
    chk("pre_rst_flags", Flags, 4'b1111);
    RegW = 1'b1; NextPC = 1'b1; #2;
    reset = 1'b1; #1;
    chk("midrst_flags", Flags, 4'b0000);
    chk("midrst_condex", {3'b0, CondExReg}, 4'h0);
    chk("midrst_pcwrite", {3'b0, PCWrite}, 4'h0);
    chk("midrst_regwrite", {3'b0, RegWrite}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    do_decode(4'b1110);
    chk("post_rst_condex", {3'b0, CondExReg}, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
